// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Two-requester arbiter and access sequencer for the 64-bit data memory.
//   The CPU port is the pipeline MEM stage and the EXT port is the debug /
//   program loader. Both share one synchronous single-port memory, one access
//   at a time. Each access walks IDLE -> ISSUE (-> WAIT -> RESP for reads),
//   and read data is returned only to the port that owns the access.
//
// Configuration macro:
//   EXT_PRIORITY_EN  defined   : on a tie EXT always wins (loader priority);
//                                the CPU can starve while ext_req_i is held.
//                    undefined : round-robin tie-break against the last
//                                served port (CPU wins the first tie).
//
// Parameters:
//   ADDR_W   memory word-address width
//   DATA_W   data width
//   MEM_LAT  read latency in cycles after the mem_en_o cycle (>= 1)
//
// Ports:
//   clk_i                 clock, all state on posedge
//   rst_i                 asynchronous active-high reset
//   cpu_req_i/_we_i       CPU request / write select (hold until cpu_gnt_o)
//   cpu_addr_i/_wdata_i   CPU word address / write data
//   cpu_gnt_o             one-cycle pulse, access issued this cycle
//   cpu_rvalid_o          one-cycle pulse, cpu_rdata_o valid
//   cpu_rdata_o           read data, held until the next CPU read completes
//   ext_*                 same set for the EXT port
//   mem_en_o/_we_o        memory strobe / write enable (we low when en low)
//   mem_addr_o/_wdata_o   memory address / write data
//   mem_rdata_i           memory read data
//   busy_o                high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,

    input  logic              ext_req_i,
    input  logic              ext_we_i,
    input  logic [ADDR_W-1:0] ext_addr_i,
    input  logic [DATA_W-1:0] ext_wdata_i,
    output logic              ext_gnt_o,
    output logic              ext_rvalid_o,
    output logic [DATA_W-1:0] ext_rdata_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_EXT = 1'b1
    } port_t;

    state_t            state_q;
    port_t             owner_q;
    port_t             last_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              cpu_gnt_q;
    logic              ext_gnt_q;
    logic              cpu_rvalid_q;
    logic              ext_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              any_req_d;
    port_t             win_d;

    // Winner selection is only consumed in IDLE; the FSM ignores it elsewhere.
    always_comb begin
        any_req_d = cpu_req_i | ext_req_i;
        win_d     = PORT_CPU;
        if (cpu_req_i && ext_req_i) begin
`ifdef EXT_PRIORITY_EN
            win_d = PORT_EXT;
`else
            win_d = (last_q == PORT_EXT) ? PORT_CPU : PORT_EXT;
`endif
        end else if (ext_req_i) begin
            win_d = PORT_EXT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_CPU;
            last_q       <= PORT_EXT;
            cnt_q        <= '0;
            cpu_gnt_q    <= 1'b0;
            ext_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            // Grant and rvalid are single-cycle pulses raised on entry to
            // ISSUE / RESP respectively.
            cpu_gnt_q    <= 1'b0;
            ext_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (any_req_d) begin
                        state_q  <= ST_ISSUE;
                        owner_q  <= win_d;
                        last_q   <= win_d;
                        mem_en_q <= 1'b1;
                        if (win_d == PORT_EXT) begin
                            ext_gnt_q   <= 1'b1;
                            mem_we_q    <= ext_we_i;
                            mem_addr_q  <= ext_addr_i;
                            mem_wdata_q <= ext_wdata_i;
                        end else begin
                            cpu_gnt_q   <= 1'b1;
                            mem_we_q    <= cpu_we_i;
                            mem_addr_q  <= cpu_addr_i;
                            mem_wdata_q <= cpu_wdata_i;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Address/data stay parked; only the strobes drop.
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    if (mem_we_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= WAIT_LOAD;
                    end
                end

                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RESP;
                        if (owner_q == PORT_EXT) begin
                            ext_rdata_q  <= mem_rdata_i;
                            ext_rvalid_q <= 1'b1;
                        end else begin
                            cpu_rdata_q  <= mem_rdata_i;
                            cpu_rvalid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_gnt_o    = cpu_gnt_q;
    assign ext_gnt_o    = ext_gnt_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign ext_rvalid_o = ext_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign ext_rdata_o  = ext_rdata_q;
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule
